// File: rtl/jtkcpu_regs.sv
// KCPU architectural register file and CC writeback stage.
// Commits ALU results, 16-bit loads, TFR/EXG and ANDCC/ORCC; drives opnd0 and the NMI-arm flag.
module jtkcpu_regs (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic [7:0]  alu_rslt,
    input  logic [7:0]  alu_cc,
    input  logic        we_a,
    input  logic        we_b,
    input  logic        we_cc,
    input  logic [15:0] d16,
    input  logic        we_d,
    input  logic        we_x,
    input  logic        we_y,
    input  logic        we_u,
    input  logic        we_s,
    input  logic        we_dp,
    input  logic        tfr,
    input  logic        exg,
    input  logic [7:0]  pbyte,
    input  logic        andcc,
    input  logic        orcc,
    input  logic [7:0]  imm,
    input  logic        sel_b,
    output logic [7:0]  opnd0,
    output logic [7:0]  a,
    output logic [7:0]  b,
    output logic [7:0]  dp,
    output logic [7:0]  cc,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic [15:0] u,
    output logic [15:0] s,
    output logic        nmi_en
);

    localparam logic [2:0] RA  = 3'd0;
    localparam logic [2:0] RB  = 3'd1;
    localparam logic [2:0] RX  = 3'd2;
    localparam logic [2:0] RY  = 3'd3;
    localparam logic [2:0] RS  = 3'd4;
    localparam logic [2:0] RU  = 3'd5;
    localparam logic [2:0] RDP = 3'd6;
    localparam logic [2:0] RCC = 3'd7;

    logic [7:0]  r_a, r_b, r_dp, r_cc;
    logic [15:0] r_x, r_y, r_u, r_s;
    logic        r_nmi_en;

    logic [7:0]  w_a, w_b, w_dp, w_cc;
    logic [15:0] w_x, w_y, w_u, w_s;
    logic        w_s_wr;
    logic [2:0]  w_src, w_dst;
    logic [15:0] w_src_val, w_dst_val;

    assign w_src = pbyte[6:4];
    assign w_dst = pbyte[2:0];

    // 8-bit registers read zero-extended so 8->16 transfers fall out naturally.
    function automatic logic [15:0] rd_reg(input logic [2:0] code,
                                           input logic [7:0] ra, input logic [7:0] rb,
                                           input logic [15:0] rx, input logic [15:0] ry,
                                           input logic [15:0] rs, input logic [15:0] ru,
                                           input logic [7:0] rdp, input logic [7:0] rcc);
        logic [15:0] v;
        v = 16'h0000;
        case (code)
            RA:      v = {8'h00, ra};
            RB:      v = {8'h00, rb};
            RX:      v = rx;
            RY:      v = ry;
            RS:      v = rs;
            RU:      v = ru;
            RDP:     v = {8'h00, rdp};
            default: v = {8'h00, rcc};
        endcase
        return v;
    endfunction

    assign w_src_val = rd_reg(w_src, r_a, r_b, r_x, r_y, r_s, r_u, r_dp, r_cc);
    assign w_dst_val = rd_reg(w_dst, r_a, r_b, r_x, r_y, r_s, r_u, r_dp, r_cc);

    always_comb begin
        w_a    = r_a;
        w_b    = r_b;
        w_x    = r_x;
        w_y    = r_y;
        w_u    = r_u;
        w_s    = r_s;
        w_dp   = r_dp;
        w_cc   = r_cc;
        w_s_wr = 1'b0;
        if (tfr || exg) begin
            // EXG writes the source back first; when src == dst both writes carry the same value.
            if (exg) begin
                case (w_src)
                    RA:      w_a  = w_dst_val[7:0];
                    RB:      w_b  = w_dst_val[7:0];
                    RX:      w_x  = w_dst_val;
                    RY:      w_y  = w_dst_val;
                    RS:      begin w_s = w_dst_val; w_s_wr = 1'b1; end
                    RU:      w_u  = w_dst_val;
                    RDP:     w_dp = w_dst_val[7:0];
                    default: w_cc = w_dst_val[7:0];
                endcase
            end
            case (w_dst)
                RA:      w_a  = w_src_val[7:0];
                RB:      w_b  = w_src_val[7:0];
                RX:      w_x  = w_src_val;
                RY:      w_y  = w_src_val;
                RS:      begin w_s = w_src_val; w_s_wr = 1'b1; end
                RU:      w_u  = w_src_val;
                RDP:     w_dp = w_src_val[7:0];
                default: w_cc = w_src_val[7:0];
            endcase
        end else begin
            if (we_d) begin
                w_a = d16[15:8];
                w_b = d16[7:0];
            end
            if (we_a)  w_a  = alu_rslt;
            if (we_b)  w_b  = alu_rslt;
            if (we_x)  w_x  = d16;
            if (we_y)  w_y  = d16;
            if (we_u)  w_u  = d16;
            if (we_dp) w_dp = d16[7:0];
            if (we_s) begin
                w_s    = d16;
                w_s_wr = 1'b1;
            end
            if (andcc)      w_cc = r_cc & imm;
            else if (orcc)  w_cc = r_cc | imm;
            else if (we_cc) w_cc = alu_cc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_x      <= 16'h0000;
            r_y      <= 16'h0000;
            r_u      <= 16'h0000;
            r_s      <= 16'h0000;
            r_dp     <= 8'h00;
            r_cc     <= 8'h50;
            r_nmi_en <= 1'b0;
        end else if (cen) begin
            r_a      <= w_a;
            r_b      <= w_b;
            r_x      <= w_x;
            r_y      <= w_y;
            r_u      <= w_u;
            r_s      <= w_s;
            r_dp     <= w_dp;
            r_cc     <= w_cc;
            r_nmi_en <= r_nmi_en | w_s_wr;
        end
    end

    assign opnd0  = sel_b ? r_b : r_a;
    assign a      = r_a;
    assign b      = r_b;
    assign x      = r_x;
    assign y      = r_y;
    assign u      = r_u;
    assign s      = r_s;
    assign dp     = r_dp;
    assign cc     = r_cc;
    assign nmi_en = r_nmi_en;

endmodule

// File: tb/tb_jtkcpu_regs.sv
// Directed bench for jtkcpu_regs: stimulus pushes hand-computed register snapshots,
// a monitor pops one after each edge and compares every output.
module tb_jtkcpu_regs;

    logic        rst, clk, cen;
    logic [7:0]  alu_rslt, alu_cc, pbyte, imm;
    logic [15:0] d16;
    logic        we_a, we_b, we_cc, we_d, we_x, we_y, we_u, we_s, we_dp;
    logic        tfr, exg, andcc, orcc, sel_b;
    logic [7:0]  opnd0, a, b, dp, cc;
    logic [15:0] x, y, u, s;
    logic        nmi_en;

    jtkcpu_regs dut (
        .rst(rst), .clk(clk), .cen(cen),
        .alu_rslt(alu_rslt), .alu_cc(alu_cc),
        .we_a(we_a), .we_b(we_b), .we_cc(we_cc),
        .d16(d16), .we_d(we_d), .we_x(we_x), .we_y(we_y), .we_u(we_u), .we_s(we_s),
        .we_dp(we_dp), .tfr(tfr), .exg(exg), .pbyte(pbyte),
        .andcc(andcc), .orcc(orcc), .imm(imm), .sel_b(sel_b),
        .opnd0(opnd0), .a(a), .b(b), .dp(dp), .cc(cc),
        .x(x), .y(y), .u(u), .s(s), .nmi_en(nmi_en)
    );

    typedef struct {
        string       name;
        logic [7:0]  a, b, dp, cc, op;
        logic [15:0] x, y, u, s;
        logic        nmi;
    } snap_t;

    snap_t sb[$];
    snap_t e;
    snap_t got;
    int    checks = 0;
    int    errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk(got.name, "a",     {8'h00, a},      {8'h00, got.a});
            chk(got.name, "b",     {8'h00, b},      {8'h00, got.b});
            chk(got.name, "x",     x,               got.x);
            chk(got.name, "y",     y,               got.y);
            chk(got.name, "u",     u,               got.u);
            chk(got.name, "s",     s,               got.s);
            chk(got.name, "dp",    {8'h00, dp},     {8'h00, got.dp});
            chk(got.name, "cc",    {8'h00, cc},     {8'h00, got.cc});
            chk(got.name, "opnd0", {8'h00, opnd0},  {8'h00, got.op});
            chk(got.name, "nmi",   {15'h0, nmi_en}, {15'h0, got.nmi});
        end
    end

    task automatic idle();
        rst = 1'b0; cen = 1'b1; sel_b = 1'b0;
        alu_rslt = 8'h00; alu_cc = 8'h00; d16 = 16'h0000; pbyte = 8'h00; imm = 8'h00;
        we_a = 1'b0; we_b = 1'b0; we_cc = 1'b0; we_d = 1'b0; we_x = 1'b0;
        we_y = 1'b0; we_u = 1'b0; we_s = 1'b0; we_dp = 1'b0;
        tfr = 1'b0; exg = 1'b0; andcc = 1'b0; orcc = 1'b0;
    endtask

    // Drive the vector's inputs before calling; the pushed snapshot is the state after the next edge.
    task automatic push(input string nm);
        e.name = nm;
        sb.push_back(e);
    endtask

    initial begin
        int wait_cyc;
        idle();
        e = '{name: "", a: 8'h00, b: 8'h00, dp: 8'h00, cc: 8'h50, op: 8'h00,
              x: 16'h0, y: 16'h0, u: 16'h0, s: 16'h0, nmi: 1'b0};

        @(negedge clk); idle(); rst = 1'b1; we_a = 1'b1; alu_rslt = 8'hFF;
        push("reset");

        @(negedge clk); idle(); alu_rslt = 8'h3C; alu_cc = 8'h04; we_a = 1'b1; we_cc = 1'b1;
        e.a = 8'h3C; e.cc = 8'h04; e.op = 8'h3C; push("alu_wb");

        @(negedge clk); idle(); cen = 1'b0; alu_rslt = 8'h77; we_a = 1'b1; we_s = 1'b1; d16 = 16'h1111;
        push("cen_hold");

        @(negedge clk); idle(); we_a = 1'b1; alu_rslt = 8'h12; we_x = 1'b1; d16 = 16'hABCD;
        e.a = 8'h12; e.x = 16'hABCD; e.op = 8'h12; push("ld_x");

        @(negedge clk); idle(); exg = 1'b1; pbyte = 8'h02; we_a = 1'b1; alu_rslt = 8'hEE;
        e.a = 8'hCD; e.x = 16'h0012; e.op = 8'hCD; push("exg_a_x");

        @(negedge clk); idle(); we_s = 1'b1; d16 = 16'h8000;
        e.s = 16'h8000; e.nmi = 1'b1; push("ld_s");

        @(negedge clk); idle(); tfr = 1'b1; pbyte = 8'h40;
        e.a = 8'h00; e.op = 8'h00; push("tfr_s_a");

        @(negedge clk); idle(); we_cc = 1'b1; alu_cc = 8'hFF;
        e.cc = 8'hFF; push("cc_ff");

        @(negedge clk); idle(); andcc = 1'b1; imm = 8'hAF; orcc = 1'b1; we_cc = 1'b1; alu_cc = 8'h00;
        e.cc = 8'hAF; push("cc_prio_and");

        @(negedge clk); idle(); orcc = 1'b1; imm = 8'h10; we_cc = 1'b1; alu_cc = 8'h00;
        e.cc = 8'hBF; push("cc_prio_or");

        @(negedge clk); idle(); we_d = 1'b1; d16 = 16'h5566; we_b = 1'b1; alu_rslt = 8'h99; sel_b = 1'b1;
        e.a = 8'h55; e.b = 8'h99; e.op = 8'h99; push("d_vs_b");

        @(negedge clk); idle(); sel_b = 1'b1; tfr = 1'b1; pbyte = 8'h12;
        e.x = 16'h0099; push("tfr_b_x");

        @(negedge clk); idle(); sel_b = 1'b1; tfr = 1'b1; exg = 1'b1; pbyte = 8'h8B;
        e.y = 16'h0055; e.a = 8'h00; push("exg_wins_bit3");

        @(negedge clk); idle(); we_y = 1'b1; we_u = 1'b1; we_dp = 1'b1; d16 = 16'hC3A5;
        e.y = 16'hC3A5; e.u = 16'hC3A5; e.dp = 8'hA5; e.op = 8'h00; push("ld_y_u_dp");

        @(negedge clk); idle(); tfr = 1'b1; pbyte = 8'h27;
        e.cc = 8'h99; push("tfr_x_cc");

        @(negedge clk); idle(); exg = 1'b1; pbyte = 8'h67;
        e.dp = 8'h99; e.cc = 8'hA5; push("exg_dp_cc");

        @(negedge clk); idle(); cen = 1'b0; tfr = 1'b1; pbyte = 8'h20;
        push("cen_hold_tfr");

        @(negedge clk); idle(); rst = 1'b1; cen = 1'b0; we_s = 1'b1; d16 = 16'hFFFF;
        e.a = 8'h00; e.b = 8'h00; e.x = 16'h0; e.y = 16'h0; e.u = 16'h0; e.s = 16'h0;
        e.dp = 8'h00; e.cc = 8'h50; e.op = 8'h00; e.nmi = 1'b0; push("reset2");

        @(negedge clk); idle(); we_x = 1'b1; d16 = 16'h2468;
        e.x = 16'h2468; push("ld_x2");

        @(negedge clk); idle(); tfr = 1'b1; pbyte = 8'h24;
        e.s = 16'h2468; e.nmi = 1'b1; push("tfr_x_s");

        @(negedge clk); idle(); we_x = 1'b1; d16 = 16'h1357;
        e.x = 16'h1357; push("nmi_sticky");

        @(negedge clk); idle(); exg = 1'b1; pbyte = 8'h55;
        push("exg_self");

        @(negedge clk); idle(); we_a = 1'b1; alu_rslt = 8'h81; andcc = 1'b1; imm = 8'h0F;
        e.a = 8'h81; e.cc = 8'h00; e.op = 8'h81; push("andcc_a");

        @(negedge clk); idle();
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
